control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Parametrised hardware successor to the hand-written T0..T5 stimulus sequence that drives DataPath.
- Fetches one instruction via PC/MAR/MDR/IR, decodes its register and opcode fields, and runs the ALU with a start/finished handshake.
- Writes results back to the register file, or to HI/LO for multiply/divide.
- Sits beside DataPath and drives its bus-select, register-enable, memory and ALU control lines.

Parameters:
- DATA_W, 32, instruction/IR width.
- RF_SEL_W, 4, register-file select width (Ra/Rb/Rc field width).
- OP_W, 5, opcode and opSelect width.
- ALU_TIMEOUT, 64, max cycles waiting on finished before error.
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before error.

Ports:
- Clock  in  1  system clock, all state on posedge.
- clear  in  1  synchronous, active-low reset.
- run  in  1  1 = keep fetching after DONE; 0 = stop in IDLE.
- ir  in  DATA_W  IR contents from DataPath.
- mem_ready  in  1  memory read data valid.
- finished  in  1  ALU completion.
- PCout, IRout, MARout, RFout, RZLOout, RZHIout, MDRout  out  1 each  bus drive selects.
- PCin, IRin, MARin, RYin, RZin, RFin, RHIin, RLOin, MDRin  out  1 each  register load enables.
- IncPC, Read, start  out  1 each  PC increment, memory read, ALU start.
- RFSelect  out  RF_SEL_W  register-file select.
- opSelect  out  OP_W  ALU operation.
- state_o  out  4  current state code.
- done  out  1  one-cycle pulse on instruction completion.
- err  out  1  sticky error flag.

Behaviour:
- Reset (clear=0 at posedge): state IDLE, every control output 0, RFSelect=0, opSelect=0, done=0, err=0.
  - Reset mid-operation aborts immediately; no partial write-back.
- All outputs are registered (Moore), decoded from the next state, so they are valid for the whole state cycle.
  - At most one *out bus select is high in any cycle.
- Decode:
  - opcode = ir[DATA_W-1 -: OP_W].
  - Ra = next RF_SEL_W bits, then Rb, then Rc.
  - For DATA_W=32: 0x28918000 -> opcode 5, Ra=1, Rb=2, Rc=3.
- States and transitions:
  - IDLE: outputs 0. Go to T0 when run=1.
  - T0: PCout, MARin, IncPC, RZin. Go to T1.
  - T1: RZLOout, PCin, Read, MDRin.
    - Hold in T1 until mem_ready=1, then go to T2.
    - More than MEM_TIMEOUT cycles -> ERR.
  - T2: MDRout, IRin. Go to T3.
  - T3: RFSelect=Rb, RFout, RYin.
    - An opcode outside the package legal set -> ERR.
    - Otherwise go to T4.
  - T4: RFSelect=Rc, RFout, opSelect=opcode, RZin, start=1 for exactly this one cycle. Go to T4W.
  - T4W: opSelect and RZin held, start=0.
    - finished=1 -> T5.
    - More than ALU_TIMEOUT cycles -> ERR.
    - finished=1 in the same cycle T4 is entered is accepted and still goes to T5.
  - T5:
    - Normal op: RFSelect=Ra, RZLOout, RFin; go to DONE.
    - MUL/DIV: RZLOout, RLOin; go to T6.
  - T6: RZHIout, RHIin. Go to DONE.
  - DONE: done=1 for one cycle. run=1 -> T0, else IDLE.
  - ERR: err=1, all controls 0. Held until clear=0.
- Timeout counters reset on every state entry.
  - Counters saturate, never wrap.
  - Counter width is $clog2 of the larger timeout plus 1.

Optional Feature:
- Macro: CONTROL_SEQUENCER_STEP_EN.
- With the macro:
  - Adds input port step (1 bit).
  - Every state transition except entry to ERR additionally requires step=1 in that cycle; otherwise the state holds.
  - Timeout counters do not advance while stalled.
- Without the macro: no step port; free-running as above.

Decomposition:
- Shared package control_pkg holds:
  - State enum codes (IDLE=0 ... ERR=10).
  - Opcode constants: ADD, SUB, AND=5, OR, MUL, DIV.
  - The legal-opcode set and the is_muldiv set.
  - Instruction field-offset constants.
- One sub-module, seq_timeout_counter: saturating counter with clear-on-entry and an expired flag, instantiated once and shared.

Test Plan:
- ir=0x28918000, mem_ready=1 in T1, finished 2 cycles after start, run=0 -> state sequence T0..T5, DONE, IDLE.
  - T3 RFSelect=2, T4 RFSelect=3 with opSelect=5, T5 RFSelect=1 with RFin=1.
  - start high for exactly 1 cycle; done pulses once.
- MUL opcode -> T5 asserts RLOin with RZLOout, T6 asserts RHIin with RZHIout; RFin never asserted.
- finished held 0 -> ERR entered at ALU_TIMEOUT+1 cycles in T4W, err stays 1, controls 0.
  - clear=0 for one cycle returns to IDLE with err=0.
- mem_ready low 5 cycles -> T1 holds 5 cycles with Read=1 and MDRin=1, then proceeds.
- run=1 across two instructions -> DONE goes directly to T0; clear=0 asserted in T4W -> IDLE next cycle, no RFin pulse.
- Illegal opcode 0x1F -> ERR after T3.
  - With CONTROL_SEQUENCER_STEP_EN defined: step=0 freezes state_o indefinitely, and each step pulse advances exactly one state.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for control_sequencer: state codes, opcode set, instruction field layout,
// and the control-line bundle registered by the sequencer.
package control_pkg;

    localparam int OPC_W  = 5;
    localparam int RA_POS = 1;
    localparam int RB_POS = 2;
    localparam int RC_POS = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T4W  = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8,
        ST_DONE = 4'd9,
        ST_ERR  = 4'd10
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
    localparam logic [OPC_W-1:0] OP_AND = 5'd5;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd6;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd7;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd8;

    typedef struct packed {
        logic pc_out;
        logic ir_out;
        logic mar_out;
        logic rf_out;
        logic rzlo_out;
        logic rzhi_out;
        logic mdr_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic ry_in;
        logic rz_in;
        logic rf_in;
        logic rhi_in;
        logic rlo_in;
        logic mdr_in;
        logic inc_pc;
        logic read;
        logic start;
        logic done;
        logic err;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating dwell counter, restarted on every state entry; expired once the count reaches limit.
// Registered count, combinational expired; en=0 freezes the count.
module seq_timeout_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= limit);

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM for DataPath; Moore outputs registered from the next state.
// Waits on mem_ready/finished with timeouts; CONTROL_SEQUENCER_STEP_EN adds a step gate on transitions.
module control_sequencer
    import control_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RF_SEL_W    = 4,
    parameter int OP_W        = OPC_W,
    parameter int ALU_TIMEOUT = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                run,
    input  logic [DATA_W-1:0]   ir,
    input  logic                mem_ready,
    input  logic                finished,
`ifdef CONTROL_SEQUENCER_STEP_EN
    input  logic                step,
`endif
    output logic                PCout,
    output logic                IRout,
    output logic                MARout,
    output logic                RFout,
    output logic                RZLOout,
    output logic                RZHIout,
    output logic                MDRout,
    output logic                PCin,
    output logic                IRin,
    output logic                MARin,
    output logic                RYin,
    output logic                RZin,
    output logic                RFin,
    output logic                RHIin,
    output logic                RLOin,
    output logic                MDRin,
    output logic                IncPC,
    output logic                Read,
    output logic                start,
    output logic [RF_SEL_W-1:0] RFSelect,
    output logic [OP_W-1:0]     opSelect,
    output logic [3:0]          state_o,
    output logic                done,
    output logic                err
);

    localparam int MAX_TO   = (ALU_TIMEOUT > MEM_TIMEOUT) ? ALU_TIMEOUT : MEM_TIMEOUT;
    localparam int CNT_W    = $clog2(MAX_TO) + 1;
    localparam int FIELD_LO = DATA_W - OP_W - 3 * RF_SEL_W;

    state_e              state_q, state_d, state_nxt;
    ctrl_t               ctrl_q, ctrl_d;
    logic [RF_SEL_W-1:0] rf_sel_q, rf_sel_d;
    logic [OP_W-1:0]     op_sel_q, op_sel_d;

    logic [OP_W-1:0]     opcode;
    logic [RF_SEL_W-1:0] ra, rb, rc;
    logic                op_legal, op_muldiv;
    logic                adv, tmo_expired;
    logic [CNT_W-1:0]    tmo_limit;
    logic                unused_ir_lo;

    assign opcode    = ir[DATA_W-1 -: OP_W];
    assign ra        = ir[DATA_W-OP_W-RA_POS*RF_SEL_W +: RF_SEL_W];
    assign rb        = ir[DATA_W-OP_W-RB_POS*RF_SEL_W +: RF_SEL_W];
    assign rc        = ir[DATA_W-OP_W-RC_POS*RF_SEL_W +: RF_SEL_W];
    assign op_legal  = is_legal_op(OPC_W'(opcode));
    assign op_muldiv = is_muldiv(OPC_W'(opcode));
    assign unused_ir_lo = ^ir[FIELD_LO-1:0];

`ifdef CONTROL_SEQUENCER_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    // One counter serves both waits; only T1 and T4W ever look at it.
    assign tmo_limit = (state_q == ST_T1) ? CNT_W'(MEM_TIMEOUT) : CNT_W'(ALU_TIMEOUT);

    seq_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk     (Clock),
        .clear   (clear),
        .restart (state_d != state_q),
        .en      (adv),
        .limit   (tmo_limit),
        .expired (tmo_expired)
    );

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: if (run) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1: begin
                if (mem_ready)        state_nxt = ST_T2;
                else if (tmo_expired) state_nxt = ST_ERR;
            end
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = op_legal ? ST_T4 : ST_ERR;
            ST_T4:   state_nxt = finished ? ST_T5 : ST_T4W;
            ST_T4W: begin
                if (finished)         state_nxt = ST_T5;
                else if (tmo_expired) state_nxt = ST_ERR;
            end
            ST_T5:   state_nxt = op_muldiv ? ST_T6 : ST_DONE;
            ST_T6:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = run ? ST_T0 : ST_IDLE;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
        // Errors are never gated by step so a hung wait still surfaces.
        state_d = (adv || (state_nxt == ST_ERR)) ? state_nxt : state_q;
    end

    always_comb begin
        ctrl_d   = '0;
        rf_sel_d = '0;
        op_sel_d = '0;
        unique case (state_d)
            ST_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.rz_in  = 1'b1;
            end
            ST_T1: begin
                ctrl_d.rzlo_out = 1'b1;
                ctrl_d.pc_in    = 1'b1;
                ctrl_d.read     = 1'b1;
                ctrl_d.mdr_in   = 1'b1;
            end
            ST_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                rf_sel_d      = rb;
                ctrl_d.rf_out = 1'b1;
                ctrl_d.ry_in  = 1'b1;
            end
            ST_T4: begin
                rf_sel_d      = rc;
                op_sel_d      = opcode;
                ctrl_d.rf_out = 1'b1;
                ctrl_d.rz_in  = 1'b1;
                ctrl_d.start  = (state_q != ST_T4);
            end
            ST_T4W: begin
                op_sel_d     = opcode;
                ctrl_d.rz_in = 1'b1;
            end
            ST_T5: begin
                ctrl_d.rzlo_out = 1'b1;
                if (op_muldiv) begin
                    ctrl_d.rlo_in = 1'b1;
                end else begin
                    rf_sel_d     = ra;
                    ctrl_d.rf_in = 1'b1;
                end
            end
            ST_T6: begin
                ctrl_d.rzhi_out = 1'b1;
                ctrl_d.rhi_in   = 1'b1;
            end
            ST_DONE: ctrl_d.done = (state_q != ST_DONE);
            ST_ERR:  ctrl_d.err  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            rf_sel_q <= '0;
            op_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            rf_sel_q <= rf_sel_d;
            op_sel_q <= op_sel_d;
        end
    end

    assign PCout    = ctrl_q.pc_out;
    assign IRout    = ctrl_q.ir_out;
    assign MARout   = ctrl_q.mar_out;
    assign RFout    = ctrl_q.rf_out;
    assign RZLOout  = ctrl_q.rzlo_out;
    assign RZHIout  = ctrl_q.rzhi_out;
    assign MDRout   = ctrl_q.mdr_out;
    assign PCin     = ctrl_q.pc_in;
    assign IRin     = ctrl_q.ir_in;
    assign MARin    = ctrl_q.mar_in;
    assign RYin     = ctrl_q.ry_in;
    assign RZin     = ctrl_q.rz_in;
    assign RFin     = ctrl_q.rf_in;
    assign RHIin    = ctrl_q.rhi_in;
    assign RLOin    = ctrl_q.rlo_in;
    assign MDRin    = ctrl_q.mdr_in;
    assign IncPC    = ctrl_q.inc_pc;
    assign Read     = ctrl_q.read;
    assign start    = ctrl_q.start;
    assign done     = ctrl_q.done;
    assign err      = ctrl_q.err;
    assign RFSelect = rf_sel_q;
    assign opSelect = op_sel_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: scenarios expand into expected per-cycle state traces that also carry stimulus.
// Each cycle compares the full output vector against the state's control table.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int ALU_TO = 64;
    localparam int MEM_TO = 16;

    localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5;
    localparam int S_T4W = 6, S_T5 = 7, S_T6 = 8, S_DONE = 9, S_ERR = 10;
    localparam int B_RFIN = 21, B_START = 15, B_DONE = 14;

    logic        Clock, clear, run, mem_ready, finished;
    logic [31:0] ir;
`ifdef CONTROL_SEQUENCER_STEP_EN
    logic        step;
`endif
    logic PCout, IRout, MARout, RFout, RZLOout, RZHIout, MDRout;
    logic PCin, IRin, MARin, RYin, RZin, RFin, RHIin, RLOin, MDRin;
    logic IncPC, Read, start, done, err;
    logic [3:0] RFSelect;
    logic [4:0] opSelect;
    logic [3:0] state_o;

    control_sequencer #(
        .DATA_W(32), .RF_SEL_W(4), .OP_W(5), .ALU_TIMEOUT(ALU_TO), .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .Clock(Clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready), .finished(finished),
`ifdef CONTROL_SEQUENCER_STEP_EN
        .step(step),
`endif
        .PCout(PCout), .IRout(IRout), .MARout(MARout), .RFout(RFout), .RZLOout(RZLOout),
        .RZHIout(RZHIout), .MDRout(MDRout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .RYin(RYin), .RZin(RZin), .RFin(RFin), .RHIin(RHIin), .RLOin(RLOin), .MDRin(MDRin),
        .IncPC(IncPC), .Read(Read), .start(start), .RFSelect(RFSelect), .opSelect(opSelect),
        .state_o(state_o), .done(done), .err(err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int          st;
        bit          mr, fin, clr, rn, stp;
        logic [31:0] irv;
    } ent_t;

    ent_t        tr[$];
    logic [31:0] cur_ir;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic add(int st, bit mr = 0, bit fin = 0, bit clr = 1, bit rn = 0, bit stp = 1);
        ent_t e;
        e.st = st; e.mr = mr; e.fin = fin; e.clr = clr; e.rn = rn; e.stp = stp; e.irv = cur_ir;
        tr.push_back(e);
    endtask

    function automatic logic [31:0] mk_ir(logic [4:0] op);
        return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    // md/ad < 0 mean the handshake never arrives.
    task automatic build_instr(int md, int ad, bit rn_last);
        logic [4:0] op = cur_ir[31:27];
        bit legal  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
        bit muldiv = (op == OP_MUL) || (op == OP_DIV);
        add(S_T0);
        if (md < 0) begin
            repeat (MEM_TO + 1) add(S_T1);
            add(S_ERR);
            return;
        end
        repeat (md) add(S_T1);
        add(S_T1, 1);
        add(S_T2);
        add(S_T3);
        if (!legal) begin
            add(S_ERR);
            return;
        end
        if (ad == 0) begin
            add(S_T4, 0, 1);
        end else begin
            add(S_T4);
            if (ad < 0) begin
                repeat (ALU_TO + 1) add(S_T4W);
                add(S_ERR);
                return;
            end
            for (int k = 1; k <= ad; k++) add(S_T4W, 0, k == ad);
        end
        add(S_T5);
        if (muldiv) add(S_T6);
        add(S_DONE, 0, 0, 1, rn_last);
    endtask

    task automatic err_recover();
        add(S_ERR);
        add(S_ERR);
        add(S_ERR, 0, 0, 0);
        add(S_IDLE);
    endtask

    function automatic logic [33:0] exp_vec(int st, int prev, logic [31:0] v);
        logic [4:0] op = v[31:27];
        logic [3:0] fa = v[26:23], fb = v[22:19], fc = v[18:15];
        logic pco = 0, iro = 0, maro = 0, rfo = 0, rzlo = 0, rzhi = 0, mdro = 0;
        logic pci = 0, iri = 0, mari = 0, ryi = 0, rzi = 0, rfi = 0, rhii = 0, rloi = 0, mdri = 0;
        logic inc = 0, rd = 0, stt = 0, dn = 0, er = 0;
        logic [3:0] sel = 0;
        logic [4:0] ops = 0;
        case (st)
            S_T0:   begin pco = 1; mari = 1; inc = 1; rzi = 1; end
            S_T1:   begin rzlo = 1; pci = 1; rd = 1; mdri = 1; end
            S_T2:   begin mdro = 1; iri = 1; end
            S_T3:   begin sel = fb; rfo = 1; ryi = 1; end
            S_T4:   begin sel = fc; rfo = 1; ops = op; rzi = 1; stt = (prev != S_T4); end
            S_T4W:  begin ops = op; rzi = 1; end
            S_T5: begin
                rzlo = 1;
                if (op == OP_MUL || op == OP_DIV) rloi = 1;
                else begin sel = fa; rfi = 1; end
            end
            S_T6:   begin rzhi = 1; rhii = 1; end
            S_DONE: dn = (prev != S_DONE);
            S_ERR:  er = 1;
            default: ;
        endcase
        return {pco, iro, maro, rfo, rzlo, rzhi, mdro, pci, iri, mari, ryi, rzi, rfi, rhii, rloi,
                mdri, inc, rd, stt, dn, er, sel, ops, 4'(st)};
    endfunction

    function automatic logic [33:0] obs_vec();
        return {PCout, IRout, MARout, RFout, RZLOout, RZHIout, MDRout, PCin, IRin, MARin, RYin,
                RZin, RFin, RHIin, RLOin, MDRin, IncPC, Read, start, done, err, RFSelect, opSelect,
                state_o};
    endfunction

    task automatic check(string tag, logic [33:0] obs, logic [33:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic check_int(string tag, int obs, int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic play(string tag);
        int prev = -1;
        int e_st = 0, o_st = 0, e_dn = 0, o_dn = 0, e_rf = 0, o_rf = 0;
        foreach (tr[i]) begin
            logic [33:0] ev = exp_vec(tr[i].st, prev, tr[i].irv);
            check($sformatf("%s cyc%0d", tag, i), obs_vec(), ev);
            e_st += int'(ev[B_START]); o_st += int'(start);
            e_dn += int'(ev[B_DONE]);  o_dn += int'(done);
            e_rf += int'(ev[B_RFIN]);  o_rf += int'(RFin);
            clear     = tr[i].clr;
            run       = tr[i].rn;
            mem_ready = tr[i].mr;
            finished  = tr[i].fin;
            ir        = tr[i].irv;
`ifdef CONTROL_SEQUENCER_STEP_EN
            step      = tr[i].stp;
`endif
            prev = tr[i].st;
            @(posedge Clock);
            #1;
        end
        check_int({tag, " start_pulses"}, o_st, e_st);
        check_int({tag, " done_pulses"}, o_dn, e_dn);
        check_int({tag, " rfin_cycles"}, o_rf, e_rf);
        tr.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] legal_ops [6];
        legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; finished = 1'b0; ir = '0; cur_ir = '0;
`ifdef CONTROL_SEQUENCER_STEP_EN
        step = 1'b0;
`endif
        @(posedge Clock);
        #1;
        add(S_IDLE, 0, 0, 0);
        add(S_IDLE);
        add(S_IDLE);
        play("reset");

        cur_ir = 32'h28918000;
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(0, 2, 0);
        add(S_IDLE);
        play("basic_and");

        cur_ir = mk_ir(OP_MUL);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(0, 1, 0);
        add(S_IDLE);
        play("mul");

        cur_ir = mk_ir(OP_SUB);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(5, 3, 0);
        add(S_IDLE);
        play("mem_wait5");

        cur_ir = mk_ir(OP_ADD);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(0, -1, 0);
        err_recover();
        play("alu_timeout");

        cur_ir = mk_ir(OP_DIV);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(-1, 0, 0);
        err_recover();
        play("mem_timeout");

        cur_ir = mk_ir(5'h1F);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(0, 1, 0);
        err_recover();
        play("illegal_op");

        cur_ir = mk_ir(OP_OR);
        add(S_IDLE, 0, 0, 1, 1);
        build_instr(1, 1, 1);
        cur_ir = mk_ir(OP_DIV);
        build_instr(0, 0, 0);
        add(S_IDLE);
        play("back_to_back");

        cur_ir = mk_ir(OP_AND);
        add(S_IDLE, 0, 0, 1, 1);
        add(S_T0); add(S_T1, 1); add(S_T2); add(S_T3); add(S_T4);
        add(S_T4W, 0, 0, 0);
        add(S_IDLE);
        add(S_IDLE);
        play("abort_t4w");

        for (int n = 0; n < 8; n++) begin
            cur_ir = mk_ir(legal_ops[$urandom_range(0, 5)]);
            add(S_IDLE, 0, 0, 1, 1);
            build_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 0);
            add(S_IDLE);
            play($sformatf("rand%0d", n));
        end

`ifdef CONTROL_SEQUENCER_STEP_EN
        cur_ir = mk_ir(OP_ADD);
        repeat (4) add(S_IDLE, 0, 0, 1, 1, 0);
        add(S_IDLE, 0, 0, 1, 1, 1);
        repeat (3) add(S_T0, 0, 0, 1, 0, 0);
        add(S_T0, 0, 0, 1, 0, 1);
        repeat (3) add(S_T1, 1, 0, 1, 0, 0);
        add(S_T1, 1, 0, 1, 0, 1);
        add(S_T2, 0, 0, 1, 0, 1);
        repeat (2) add(S_T3, 0, 0, 1, 0, 0);
        add(S_T3, 0, 0, 1, 0, 1);
        repeat (2) add(S_T4, 0, 0, 1, 0, 0);
        add(S_T4, 0, 0, 1, 0, 1);
        add(S_T4W, 0, 1, 1, 0, 1);
        add(S_T5, 0, 0, 1, 0, 1);
        repeat (2) add(S_DONE, 0, 0, 1, 0, 0);
        add(S_DONE, 0, 0, 1, 0, 1);
        add(S_IDLE);
        play("step");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
